// File: rtl/status_pkg.sv
// -----------------------------------------------------------------------------
// status_pkg
// Shared definitions for the status history buffer:
//   clog2          - ceiling log2, usable in parameter expressions
//   DEF_WIDTH      - default status word width
//   DEF_DEPTH      - default history depth (power of two)
//   status_word_t  - status word type at the default width
// -----------------------------------------------------------------------------
package status_pkg;

   localparam int DEF_WIDTH = 35;
   localparam int DEF_DEPTH = 8;

   typedef logic [DEF_WIDTH-1:0] status_word_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/history_ram.sv
// -----------------------------------------------------------------------------
// history_ram
// Simple dual-port WIDTH x DEPTH storage array.
// Ports:
//   clk    in            - clock
//   we     in            - write enable
//   waddr  in  [AW-1:0]  - write address
//   wdata  in  [WIDTH-1:0] - write data
//   re     in            - read enable
//   raddr  in  [AW-1:0]  - read address
//   rdata  out [WIDTH-1:0] - registered read data, held while re is low
// A read and a write to the same address in one cycle returns the old word.
// -----------------------------------------------------------------------------
module history_ram #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array and its read register carry no reset so they map onto
   // plain RAM; the top level masks rdata until a real pop has happened.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/status_history_buffer.sv
// -----------------------------------------------------------------------------
// status_history_buffer
// Circular history of the last DEPTH controller status words, drained
// oldest-first through a pop port.
// Ports:
//   clk        in              - clock, rising edge
//   arst       in              - asynchronous active-high reset
//   clr        in              - synchronous clear (beats rden/wren)
//   wren       in              - write request
//   din        in  [WIDTH-1:0] - word to store
//   rden       in              - pop request for the oldest word
//   dout       out [WIDTH-1:0] - last popped word, held until the next pop
//   dout_valid out             - one-cycle pulse after an accepted pop
//   latest     out [WIDTH-1:0] - most recently accepted write
//   count      out [CW-1:0]    - stored words, 0..DEPTH
//   empty      out             - count == 0
//   full       out             - count == DEPTH
//   overflow   out             - sticky, set by a write while full without pop
// -----------------------------------------------------------------------------
module status_history_buffer
   import status_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter bit OVERWRITE = 1'b1,
   parameter int CW        = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             clr,
   input  logic             wren,
   input  logic [WIDTH-1:0] din,
   input  logic             rden,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [WIDTH-1:0] latest,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int AW = clog2(DEPTH);

   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             dout_live;   // a pop has happened since reset/clear
   logic [WIDTH-1:0] ram_q;

   logic pop;
   logic wr_ok;
   logic wr_over;   // accepted write that displaces the oldest word

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A pop and a write while full cancel out, so the write is always
   // accepted in that case, even in drop mode.
   assign pop     = rden && !empty && !clr;
   assign wr_ok   = wren && !clr && (!full || pop || OVERWRITE);
   assign wr_over = wr_ok && full && !pop;

   history_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wptr),
      .wdata (din),
      .re    (pop),
      .raddr (rptr),
      .rdata (ram_q)
   );

   // The unreset RAM register is hidden until it holds a popped word.
   assign dout = dout_live ? ram_q : '0;

   // NOTE: every register here uses non-blocking assignment so all state
   // updates see the pre-edge values of pointers, count and flags.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         latest     <= '0;
         dout_valid <= 1'b0;
         dout_live  <= 1'b0;
         overflow   <= 1'b0;
      end else if (clr) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         latest     <= '0;
         dout_valid <= 1'b0;
         dout_live  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         dout_valid <= pop;
         if (pop) dout_live <= 1'b1;

         if (wr_ok) begin
            wptr   <= wptr + AW'(1);
            latest <= din;
         end

         // Overwrite while full drags the read pointer along with wptr.
         if (pop || wr_over) rptr <= rptr + AW'(1);

         if (wr_ok && !pop && !full)  count <= count + CW'(1);
         else if (pop && !wr_ok)      count <= count - CW'(1);

         if (wren && full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_status_history_buffer.sv
// -----------------------------------------------------------------------------
// tb_status_history_buffer
// Directed bench driving one overwrite-mode and one drop-mode instance with
// the same stimulus and checking both against hand-computed values.
// -----------------------------------------------------------------------------
module tb_status_history_buffer;

   localparam int WIDTH = 35;
   localparam int CW    = 4;

   logic             clk = 1'b0;
   logic             arst = 1'b0;
   logic             clr = 1'b0;
   logic             wren = 1'b0;
   logic             rden = 1'b0;
   logic [WIDTH-1:0] din = '0;

   logic [WIDTH-1:0] ow_dout, ow_latest, dp_dout, dp_latest;
   logic [CW-1:0]    ow_count, dp_count;
   logic             ow_dv, ow_empty, ow_full, ow_ovf;
   logic             dp_dv, dp_empty, dp_full, dp_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   status_history_buffer #(.WIDTH(WIDTH), .DEPTH(8), .OVERWRITE(1'b1)) u_ow (
      .clk(clk), .arst(arst), .clr(clr), .wren(wren), .din(din), .rden(rden),
      .dout(ow_dout), .dout_valid(ow_dv), .latest(ow_latest), .count(ow_count),
      .empty(ow_empty), .full(ow_full), .overflow(ow_ovf)
   );

   status_history_buffer #(.WIDTH(WIDTH), .DEPTH(8), .OVERWRITE(1'b0)) u_dp (
      .clk(clk), .arst(arst), .clr(clr), .wren(wren), .din(din), .rden(rden),
      .dout(dp_dout), .dout_valid(dp_dv), .latest(dp_latest), .count(dp_count),
      .empty(dp_empty), .full(dp_full), .overflow(dp_ovf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the given request lines, outputs settled after.
   task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
      wren = w;
      din  = d;
      rden = r;
      clr  = c;
      @(posedge clk);
      #1;
      wren = 1'b0;
      rden = 1'b0;
      clr  = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " ow dout"},   64'(ow_dout),   64'h0);
      check({tag, " ow dv"},     64'(ow_dv),     64'h0);
      check({tag, " ow latest"}, 64'(ow_latest), 64'h0);
      check({tag, " ow count"},  64'(ow_count),  64'h0);
      check({tag, " ow empty"},  64'(ow_empty),  64'h1);
      check({tag, " ow full"},   64'(ow_full),   64'h0);
      check({tag, " ow ovf"},    64'(ow_ovf),    64'h0);
      check({tag, " dp dout"},   64'(dp_dout),   64'h0);
      check({tag, " dp count"},  64'(dp_count),  64'h0);
      check({tag, " dp empty"},  64'(dp_empty),  64'h1);
   endtask

   initial begin
      // ---- reset ----------------------------------------------------------
      @(negedge clk);
      arst = 1'b1;
      #1;
      check_reset_state("reset");
      @(negedge clk);
      arst = 1'b0;

      // ---- three writes, three back-to-back pops ------------------------
      for (int i = 1; i <= 3; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      check("w3 count",  64'(ow_count),  64'd3);
      check("w3 latest", 64'(ow_latest), 64'h3);
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         check($sformatf("pop%0d dout", i), 64'(ow_dout), 64'(i));
         check($sformatf("pop%0d dv", i),   64'(ow_dv),   64'h1);
      end
      step(1'b0, '0, 1'b0, 1'b0);
      check("idle dv",    64'(ow_dv),    64'h0);
      check("idle dout",  64'(ow_dout),  64'h3);
      check("idle empty", 64'(ow_empty), 64'h1);

      // ---- write 1..10 into both modes -----------------------------------
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 1; i <= 10; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      check("ow full",   64'(ow_full),   64'h1);
      check("ow ovf",    64'(ow_ovf),    64'h1);
      check("ow count",  64'(ow_count),  64'd8);
      check("ow latest", 64'(ow_latest), 64'd10);
      check("dp full",   64'(dp_full),   64'h1);
      check("dp ovf",    64'(dp_ovf),    64'h1);
      check("dp count",  64'(dp_count),  64'd8);
      check("dp latest", 64'(dp_latest), 64'd8);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         check($sformatf("ow drain%0d", i), 64'(ow_dout), 64'(i + 3));
         check($sformatf("dp drain%0d", i), 64'(dp_dout), 64'(i + 1));
      end
      check("drained ow empty", 64'(ow_empty), 64'h1);
      check("drained dp empty", 64'(dp_empty), 64'h1);

      // ---- simultaneous pop and write while full -------------------------
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      step(1'b1, WIDTH'(9), 1'b1, 1'b0);
      check("pw ow dout",   64'(ow_dout),   64'd1);
      check("pw ow count",  64'(ow_count),  64'd8);
      check("pw ow ovf",    64'(ow_ovf),    64'h0);
      check("pw ow latest", 64'(ow_latest), 64'd9);
      check("pw dp dout",   64'(dp_dout),   64'd1);
      check("pw dp count",  64'(dp_count),  64'd8);
      check("pw dp ovf",    64'(dp_ovf),    64'h0);
      check("pw dp latest", 64'(dp_latest), 64'd9);

      // ---- simultaneous pop and write while empty ------------------------
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, WIDTH'(5), 1'b1, 1'b0);
      check("pe ow count", 64'(ow_count), 64'd1);
      check("pe ow dv",    64'(ow_dv),    64'h0);
      check("pe ow dout",  64'(ow_dout),  64'h0);
      check("pe dp count", 64'(dp_count), 64'd1);

      // ---- clear together with a write -----------------------------------
      for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16 + i), 1'b0, 1'b0);
      check("pre-clr ow ovf", 64'(ow_ovf), 64'h1);
      check("pre-clr dp ovf", 64'(dp_ovf), 64'h1);
      step(1'b1, WIDTH'(85), 1'b0, 1'b1);
      check("clr ow count",  64'(ow_count),  64'd0);
      check("clr ow ovf",    64'(ow_ovf),    64'h0);
      check("clr ow latest", 64'(ow_latest), 64'h0);
      check("clr dp ovf",    64'(dp_ovf),    64'h0);

      // ---- asynchronous reset between edges ------------------------------
      step(1'b1, WIDTH'(33), 1'b0, 1'b0);
      step(1'b1, WIDTH'(34), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("pre-arst dout", 64'(ow_dout), 64'd33);
      check("pre-arst dv",   64'(ow_dv),   64'h1);
      #2;
      arst = 1'b1;
      #1;
      check_reset_state("arst");
      #1;
      arst = 1'b0;
      step(1'b1, WIDTH'(10), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("post-arst dout", 64'(ow_dout), 64'd10);

      // ---- wrap both pointers with interleaved write/pop pairs -----------
      for (int i = 0; i < 20; i++) begin
         step(1'b1, WIDTH'(256 + i), 1'b0, 1'b0);
         step(1'b0, '0, 1'b1, 1'b0);
         check($sformatf("wrap%0d ow", i), 64'(ow_dout), 64'(256 + i));
         check($sformatf("wrap%0d dp", i), 64'(dp_dout), 64'(256 + i));
      end

      // ---- pop while empty -----------------------------------------------
      step(1'b0, '0, 1'b1, 1'b0);
      check("empty-pop dout",  64'(ow_dout),  64'd275);
      check("empty-pop dv",    64'(ow_dv),    64'h0);
      check("empty-pop count", 64'(ow_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
